// File: rtl/cve2_clint_if.sv
// Data-bus bundle between the core-side bus decoder (master) and the
// CLINT responder (slave). One request per cycle, one response cycle later.
interface cve2_clint_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );
endinterface

// File: rtl/cve2_clint.sv
// cve2_clint: core-local interrupt block. Holds mtime/mtimecmp, msip and the
// fast-interrupt pending/enable registers, answers the data bus one cycle
// after grant, and drives the core's software/timer/external/fast irq inputs.
//
// Optional feature macro: CVE2_CLINT_FAST_IRQ_EN
//   defined   -> FASTIP/FASTIE, source edge detectors and irq_fast_o exist
//   undefined -> FASTIP/FASTIE read 0 and ignore writes, irq_fast_o = 0
//
// Response FSM states:
//   state | meaning
//   IDLE  | no response pending this cycle
//   RESP  | rvalid asserted with the data latched at the grant edge
module cve2_clint #(
  parameter logic [31:0] BaseAddr      = 32'h0200_0000,
  parameter logic [63:0] MtimeResetVal = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        irq_external_i,
  input  logic [14:0] irq_fast_src_i,
  cve2_clint_if.slave bus,
  output logic        irq_software_o,
  output logic        irq_timer_o,
  output logic        irq_external_o,
  output logic [14:0] irq_fast_o
);

  typedef enum logic {IDLE, RESP} state_e;

  localparam logic [15:0] OffMsip     = 16'h0000;
  localparam logic [15:0] OffFastip   = 16'h0004;
  localparam logic [15:0] OffFastie   = 16'h0008;
  localparam logic [15:0] OffCmpLo    = 16'h4000;
  localparam logic [15:0] OffCmpHi    = 16'h4004;
  localparam logic [15:0] OffMtimeLo  = 16'hBFF8;
  localparam logic [15:0] OffMtimeHi  = 16'hBFFC;

  state_e      state_q, state_d;
  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_q, mtime_d;
  logic        irq_timer_q, irq_timer_d;
  logic        irq_ext_q, irq_ext_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        addr_hit;
  logic [15:0] offset;
  logic        sel_msip, sel_fastip, sel_fastie;
  logic        sel_cmp_lo, sel_cmp_hi, sel_mtime_lo, sel_mtime_hi;
  logic        reg_mapped;
  logic        wr_en;
  logic [31:0] be_mask;
  logic [31:0] rd_data;
  logic [31:0] fastip_rd, fastie_rd;
  logic        gnt, rvalid;
  logic        unused_addr_lsb;

  function automatic logic [31:0] merge_be(logic [31:0] old_val, logic [31:0] new_val,
                                           logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // Address decode; word-aligned offsets only, so addr[1:0] is dropped
  assign addr_hit        = (bus.data_addr[31:16] == BaseAddr[31:16]);
  assign offset          = {bus.data_addr[15:2], 2'b00};
  assign unused_addr_lsb = ^bus.data_addr[1:0];

  assign sel_msip     = addr_hit && (offset == OffMsip);
  assign sel_fastip   = addr_hit && (offset == OffFastip);
  assign sel_fastie   = addr_hit && (offset == OffFastie);
  assign sel_cmp_lo   = addr_hit && (offset == OffCmpLo);
  assign sel_cmp_hi   = addr_hit && (offset == OffCmpHi);
  assign sel_mtime_lo = addr_hit && (offset == OffMtimeLo);
  assign sel_mtime_hi = addr_hit && (offset == OffMtimeHi);
  assign reg_mapped   = sel_msip | sel_fastip | sel_fastie | sel_cmp_lo | sel_cmp_hi |
                        sel_mtime_lo | sel_mtime_hi;

  // The responder is always ready, so every request is a granted one
  assign wr_en = bus.data_req & bus.data_we;

  // Expand byte enables to a bit mask
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < 4; b++) begin
      be_mask[b*8 +: 8] = {8{bus.data_be[b]}};
    end
  end

  // Core register next-state: bus writes, mtime increment (write beats tick)
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;
    if (wr_en && sel_msip && bus.data_be[0]) begin
      msip_d = bus.data_wdata[0];
    end
    if (wr_en && sel_cmp_lo) begin
      mtimecmp_d[31:0] = merge_be(mtimecmp_q[31:0], bus.data_wdata, be_mask);
    end
    if (wr_en && sel_cmp_hi) begin
      mtimecmp_d[63:32] = merge_be(mtimecmp_q[63:32], bus.data_wdata, be_mask);
    end
    if (wr_en && (sel_mtime_lo || sel_mtime_hi)) begin
      if (sel_mtime_lo) begin
        mtime_d[31:0] = merge_be(mtime_q[31:0], bus.data_wdata, be_mask);
      end
      if (sel_mtime_hi) begin
        mtime_d[63:32] = merge_be(mtime_q[63:32], bus.data_wdata, be_mask);
      end
    end else if (tick_i) begin
      mtime_d = mtime_q + 64'd1;
    end
    irq_timer_d = (mtime_q >= mtimecmp_q);
    irq_ext_d   = irq_external_i;
  end

`ifdef CVE2_CLINT_FAST_IRQ_EN
  logic [14:0] fastip_q, fastip_d;
  logic [14:0] fastie_q, fastie_d;
  logic [14:0] src_q, src_d;
  logic [14:0] fast_clr;
  logic [31:0] fastie_wr;

  // Fast irq next-state: a new source edge wins over a same-cycle W1C
  always_comb begin
    fast_clr  = (wr_en && sel_fastip) ? (bus.data_wdata[14:0] & be_mask[14:0]) : 15'b0;
    fastip_d  = (fastip_q & ~fast_clr) | (irq_fast_src_i & ~src_q);
    fastie_wr = merge_be({17'b0, fastie_q}, bus.data_wdata, be_mask);
    fastie_d  = (wr_en && sel_fastie) ? fastie_wr[14:0] : fastie_q;
    src_d     = irq_fast_src_i;
  end

  // Fast irq registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fastip_q <= '0;
      fastie_q <= '0;
      src_q    <= '0;
    end else begin
      fastip_q <= fastip_d;
      fastie_q <= fastie_d;
      src_q    <= src_d;
    end
  end

  assign fastip_rd  = {17'b0, fastip_q};
  assign fastie_rd  = {17'b0, fastie_q};
  assign irq_fast_o = fastip_q & fastie_q;
`else
  logic unused_fast_src;
  assign unused_fast_src = ^irq_fast_src_i;
  assign fastip_rd       = '0;
  assign fastie_rd       = '0;
  assign irq_fast_o      = '0;
`endif

  // Read mux on pre-write register state; unmapped offsets read 0 with error
  always_comb begin
    rd_data = '0;
    if (sel_msip)     rd_data = {31'b0, msip_q};
    if (sel_fastip)   rd_data = fastip_rd;
    if (sel_fastie)   rd_data = fastie_rd;
    if (sel_cmp_lo)   rd_data = mtimecmp_q[31:0];
    if (sel_cmp_hi)   rd_data = mtimecmp_q[63:32];
    if (sel_mtime_lo) rd_data = mtime_q[31:0];
    if (sel_mtime_hi) rd_data = mtime_q[63:32];
    rdata_d = bus.data_req ? rd_data : 32'h0;
    err_d   = bus.data_req & ~reg_mapped;
  end

  // FSM next state: a grant in either state leads to a response next cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.data_req ? RESP : IDLE;
      RESP:    state_d = bus.data_req ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    gnt    = bus.data_req;
    rvalid = (state_q == RESP);
  end

  // State and register flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      msip_q      <= 1'b0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_q     <= MtimeResetVal;
      irq_timer_q <= 1'b0;
      irq_ext_q   <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      msip_q      <= msip_d;
      mtimecmp_q  <= mtimecmp_d;
      mtime_q     <= mtime_d;
      irq_timer_q <= irq_timer_d;
      irq_ext_q   <= irq_ext_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.data_gnt    = gnt;
  assign bus.data_rvalid = rvalid;
  assign bus.data_rdata  = rdata_q;
  assign bus.data_err    = err_q;

  assign irq_software_o = msip_q;
  assign irq_timer_o    = irq_timer_q;
  assign irq_external_o = irq_ext_q;

endmodule

// File: tb/tb_cve2_clint.sv
// Self-checking bench for cve2_clint: directed scenarios plus a randomized
// run compared against a register-level behavioural model.
module tb_cve2_clint;
  localparam logic [31:0] Base = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst, tick, ext;
  logic [14:0] src;
  logic        sw_o, tmr_o, ext_o;
  logic [14:0] fast_o;

  cve2_clint_if bus();

  cve2_clint dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tick_i         (tick),
    .irq_external_i (ext),
    .irq_fast_src_i (src),
    .bus            (bus),
    .irq_software_o (sw_o),
    .irq_timer_o    (tmr_o),
    .irq_external_o (ext_o),
    .irq_fast_o     (fast_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip;
  logic [14:0] m_fastip, m_fastie, m_src;
  logic        e_rvalid, e_err, e_timer, e_ext;
  logic [31:0] e_rdata;

  function automatic logic [31:0] m_merge(logic [31:0] old_v, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_w1c(logic [31:0] old_v, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = old_v[b*8 +: 8] & ~wd[b*8 +: 8];
    return r;
  endfunction

  // returns {err, data}
  function automatic logic [32:0] m_read(logic [31:0] a);
    if (a[31:16] != Base[31:16]) return {1'b1, 32'h0};
    case ({a[15:2], 2'b00})
      16'h0000: return {1'b0, 31'h0, m_msip};
      16'h0004: return {1'b0, 17'h0, m_fastip};
      16'h0008: return {1'b0, 17'h0, m_fastie};
      16'h4000: return {1'b0, m_cmp[31:0]};
      16'h4004: return {1'b0, m_cmp[63:32]};
      16'hBFF8: return {1'b0, m_mtime[31:0]};
      16'hBFFC: return {1'b0, m_mtime[63:32]};
      default:  return {1'b1, 32'h0};
    endcase
  endfunction

  // Advance one clock; the model applies the same inputs the DUT sees.
  task automatic tick_clk();
    logic [63:0] n_mtime, n_cmp;
    logic        n_msip, wr;
    logic [14:0] n_fip, n_fie;
    logic [31:0] tmp;
    logic [32:0] rd;
    n_mtime = tick ? m_mtime + 64'd1 : m_mtime;
    n_cmp   = m_cmp;
    n_msip  = m_msip;
    n_fip   = m_fastip;
    n_fie   = m_fastie;
    rd      = m_read(bus.data_addr);
    wr      = bus.data_req && bus.data_we && (bus.data_addr[31:16] == Base[31:16]);
    if (wr) begin
      case ({bus.data_addr[15:2], 2'b00})
        16'h0000: if (bus.data_be[0]) n_msip = bus.data_wdata[0];
        16'h4000: n_cmp[31:0]  = m_merge(m_cmp[31:0], bus.data_wdata, bus.data_be);
        16'h4004: n_cmp[63:32] = m_merge(m_cmp[63:32], bus.data_wdata, bus.data_be);
        16'hBFF8: n_mtime = {m_mtime[63:32], m_merge(m_mtime[31:0], bus.data_wdata, bus.data_be)};
        16'hBFFC: n_mtime = {m_merge(m_mtime[63:32], bus.data_wdata, bus.data_be), m_mtime[31:0]};
`ifdef CVE2_CLINT_FAST_IRQ_EN
        16'h0004: begin
          tmp   = m_w1c({17'h0, m_fastip}, bus.data_wdata, bus.data_be);
          n_fip = tmp[14:0];
        end
        16'h0008: begin
          tmp   = m_merge({17'h0, m_fastie}, bus.data_wdata, bus.data_be);
          n_fie = tmp[14:0];
        end
`endif
        default: ;
      endcase
    end
`ifdef CVE2_CLINT_FAST_IRQ_EN
    n_fip = n_fip | (src & ~m_src);
`endif
    @(posedge clk);
    if (rst) begin
      m_mtime = 64'h0; m_cmp = '1; m_msip = 1'b0;
      m_fastip = '0; m_fastie = '0; m_src = '0;
      e_rvalid = 1'b0; e_err = 1'b0; e_timer = 1'b0; e_ext = 1'b0; e_rdata = '0;
    end else begin
      e_timer  = (m_mtime >= m_cmp);
      e_ext    = ext;
      e_rvalid = bus.data_req;
      e_rdata  = bus.data_req ? rd[31:0] : 32'h0;
      e_err    = bus.data_req & rd[32];
      m_mtime = n_mtime; m_cmp = n_cmp; m_msip = n_msip;
      m_fastip = n_fip; m_fastie = n_fie; m_src = src;
    end
    #1;
  endtask

  task automatic bus_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output logic err, output logic rv);
    bus.data_req = 1'b1; bus.data_we = we; bus.data_be = be;
    bus.data_addr = addr; bus.data_wdata = wd;
    tick_clk();
    rv = bus.data_rvalid; rdata = bus.data_rdata; err = bus.data_err;
    bus.data_req = 1'b0; bus.data_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er, rv;
    rst = 1'b1; tick = 1'b0; ext = 1'b0; src = '0;
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_be = 4'hF;
    bus.data_addr = Base; bus.data_wdata = '0;
    repeat (3) tick_clk();
    rst = 1'b0;
    tick_clk();
    checks++; if ({bus.data_rvalid, sw_o, tmr_o, ext_o} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs got rv/sw/tmr/ext=%b expected 0000",
                         {bus.data_rvalid, sw_o, tmr_o, ext_o}); end
    checks++; if (fast_o !== 15'h0) begin
      errors++; $display("FAIL reset_fast got %h expected 0", fast_o); end
    // grant is combinational, rvalid follows exactly one cycle later
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = Base + 32'h4004;
    #1;
    checks++; if ({bus.data_gnt, bus.data_rvalid} !== 2'b10) begin
      errors++; $display("FAIL gnt_cycle got gnt/rv=%b expected 10", {bus.data_gnt, bus.data_rvalid}); end
    tick_clk();
    bus.data_req = 1'b0;
    checks++; if ({bus.data_rvalid, bus.data_err, bus.data_rdata} !== {2'b10, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL cmp_hi_reset got rv=%b err=%b data=%h expected rv=1 err=0 data=ffffffff",
                         bus.data_rvalid, bus.data_err, bus.data_rdata); end
    tick_clk();
    checks++; if (bus.data_rvalid !== 1'b0) begin
      errors++; $display("FAIL rvalid_one_cycle got %b expected 0", bus.data_rvalid); end
    bus_op(1'b0, 4'hF, Base + 32'h4000, 32'h0, rd, er, rv);
    checks++; if ({rv, er, rd, tmr_o} !== {2'b10, 32'hFFFF_FFFF, 1'b0}) begin
      errors++; $display("FAIL cmp_lo_reset got rv=%b err=%b data=%h tmr=%b expected 1 0 ffffffff 0",
                         rv, er, rd, tmr_o); end
  endtask

  task automatic test_mtime_carry();
    logic [31:0] rd; logic er, rv;
    bus_op(1'b1, 4'hF, Base + 32'hBFFC, 32'h0, rd, er, rv);
    bus_op(1'b1, 4'hF, Base + 32'hBFF8, 32'hFFFF_FFFE, rd, er, rv);
    tick = 1'b1;
    repeat (3) tick_clk();
    tick = 1'b0;
    bus_op(1'b0, 4'hF, Base + 32'hBFFC, 32'h0, rd, er, rv);
    checks++; if (rd !== 32'h1) begin
      errors++; $display("FAIL mtime_hi_carry got %h expected 00000001", rd); end
    bus_op(1'b0, 4'hF, Base + 32'hBFF8, 32'h0, rd, er, rv);
    checks++; if (rd !== 32'h1) begin
      errors++; $display("FAIL mtime_lo_carry got %h expected 00000001", rd); end
    // tick colliding with an MTIME lo write: written value wins, no increment
    tick = 1'b1;
    bus_op(1'b1, 4'hF, Base + 32'hBFF8, 32'h0000_0050, rd, er, rv);
    tick = 1'b0;
    bus_op(1'b0, 4'hF, Base + 32'hBFF8, 32'h0, rd, er, rv);
    checks++; if (rd !== 32'h50) begin
      errors++; $display("FAIL mtime_write_vs_tick got %h expected 00000050", rd); end
  endtask

  task automatic test_timer();
    logic [31:0] rd; logic er, rv;
    bus_op(1'b1, 4'hF, Base + 32'hBFFC, 32'h0, rd, er, rv);
    bus_op(1'b1, 4'hF, Base + 32'hBFF8, 32'h0E, rd, er, rv);
    bus_op(1'b1, 4'hF, Base + 32'h4000, 32'h10, rd, er, rv);
    bus_op(1'b1, 4'hF, Base + 32'h4004, 32'h0, rd, er, rv);
    tick = 1'b1;
    repeat (2) tick_clk();
    tick = 1'b0;
    checks++; if (tmr_o !== 1'b0) begin
      errors++; $display("FAIL timer_before got %b expected 0", tmr_o); end
    tick_clk();
    checks++; if (tmr_o !== 1'b1) begin
      errors++; $display("FAIL timer_rise got %b expected 1", tmr_o); end
    bus_op(1'b1, 4'hF, Base + 32'h4000, 32'h100, rd, er, rv);
    checks++; if (tmr_o !== 1'b1) begin
      errors++; $display("FAIL timer_hold got %b expected 1", tmr_o); end
    tick_clk();
    checks++; if (tmr_o !== 1'b0) begin
      errors++; $display("FAIL timer_fall got %b expected 0", tmr_o); end
  endtask

  task automatic test_fast();
    logic [31:0] rd; logic er, rv;
    bus_op(1'b1, 4'hF, Base + 32'h0008, 32'h1, rd, er, rv);
    src = 15'h1;
    tick_clk();
    src = 15'h0;
`ifdef CVE2_CLINT_FAST_IRQ_EN
    checks++; if (fast_o !== 15'h1) begin
      errors++; $display("FAIL fast_set got %h expected 0001", fast_o); end
    tick_clk();
    src = 15'h1;
    bus_op(1'b1, 4'h1, Base + 32'h0004, 32'h1, rd, er, rv);
    src = 15'h0;
    checks++; if (fast_o !== 15'h1) begin
      errors++; $display("FAIL fast_set_wins got %h expected 0001", fast_o); end
    bus_op(1'b1, 4'h0, Base + 32'h0004, 32'h1, rd, er, rv);
    checks++; if (fast_o !== 15'h1) begin
      errors++; $display("FAIL fast_w1c_be0 got %h expected 0001", fast_o); end
    bus_op(1'b1, 4'h1, Base + 32'h0004, 32'h1, rd, er, rv);
    checks++; if (fast_o !== 15'h0) begin
      errors++; $display("FAIL fast_clear got %h expected 0000", fast_o); end
`else
    checks++; if (fast_o !== 15'h0) begin
      errors++; $display("FAIL fast_disabled got %h expected 0000", fast_o); end
    bus_op(1'b0, 4'hF, Base + 32'h0008, 32'h0, rd, er, rv);
    checks++; if ({er, rd} !== 33'h0) begin
      errors++; $display("FAIL fastie_disabled got err=%b data=%h expected 0 0", er, rd); end
`endif
  endtask

  task automatic test_msip();
    logic [31:0] rd; logic er, rv;
    bus_op(1'b1, 4'h0, Base, 32'hFFFF_FFFF, rd, er, rv);
    bus_op(1'b0, 4'hF, Base, 32'h0, rd, er, rv);
    checks++; if ({rd, sw_o} !== 33'h0) begin
      errors++; $display("FAIL msip_be0 got data=%h sw=%b expected 0 0", rd, sw_o); end
    bus_op(1'b1, 4'h1, Base, 32'hFFFF_FFFF, rd, er, rv);
    checks++; if (sw_o !== 1'b1) begin
      errors++; $display("FAIL msip_irq got %b expected 1", sw_o); end
    bus_op(1'b0, 4'hF, Base, 32'h0, rd, er, rv);
    checks++; if (rd !== 32'h1) begin
      errors++; $display("FAIL msip_read got %h expected 00000001", rd); end
    bus_op(1'b1, 4'hF, Base, 32'h0, rd, er, rv);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, rv;
    bus_op(1'b0, 4'hF, Base + 32'h2000, 32'h0, rd, er, rv);
    checks++; if ({rv, er, rd} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL err_offset got rv=%b err=%b data=%h expected 1 1 0", rv, er, rd); end
    bus_op(1'b1, 4'hF, 32'h0300_0000, 32'h1, rd, er, rv);
    checks++; if ({rv, er, sw_o} !== 3'b110) begin
      errors++; $display("FAIL err_base_write got rv/err/sw=%b expected 110", {rv, er, sw_o}); end
    bus_op(1'b0, 4'hF, 32'h0300_0000, 32'h0, rd, er, rv);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL err_base_read got err=%b data=%h expected 1 0", er, rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4] = '{Base + 32'h4004, Base + 32'hBFF8, Base + 32'h1000, Base};
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      bus.data_addr = addrs[i];
      tick_clk();
      checks++; if ({bus.data_rvalid, bus.data_err, bus.data_rdata} !== {1'b1, e_err, e_rdata}) begin
        errors++; $display("FAIL b2b_%0d got rv=%b err=%b data=%h expected 1 %b %h", i,
                           bus.data_rvalid, bus.data_err, bus.data_rdata, e_err, e_rdata); end
    end
    bus.data_req = 1'b0;
    tick_clk();
    checks++; if (bus.data_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_end got rv=%b expected 0", bus.data_rvalid); end
  endtask

  task automatic test_random();
    logic [31:0] addrs [9] = '{Base, Base + 32'h4, Base + 32'h8, Base + 32'h4000, Base + 32'h4004,
                               Base + 32'hBFF8, Base + 32'hBFFC, Base + 32'h2000, 32'h0300_0000};
    for (int n = 0; n < 400; n++) begin
      bus.data_req   = ($urandom_range(0, 9) < 7);
      bus.data_we    = $urandom_range(0, 1);
      bus.data_be    = 4'($urandom);
      bus.data_addr  = addrs[$urandom_range(0, 8)] | 32'($urandom_range(0, 3));
      bus.data_wdata = (bus.data_addr[15:12] == 4'hB && $urandom_range(0, 1) == 1) ?
                       32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      tick = $urandom_range(0, 1);
      ext  = $urandom_range(0, 1);
      src  = 15'($urandom);
      tick_clk();
      checks++; if (bus.data_rvalid !== e_rvalid) begin
        errors++; $display("FAIL rnd_rvalid[%0d] got %b expected %b", n, bus.data_rvalid, e_rvalid); end
      if (e_rvalid) begin
        checks++; if ({bus.data_err, bus.data_rdata} !== {e_err, e_rdata}) begin
          errors++; $display("FAIL rnd_resp[%0d] got err=%b data=%h expected %b %h", n,
                             bus.data_err, bus.data_rdata, e_err, e_rdata); end
      end
      checks++; if ({sw_o, tmr_o, ext_o} !== {m_msip, e_timer, e_ext}) begin
        errors++; $display("FAIL rnd_irq[%0d] got sw/tmr/ext=%b expected %b", n,
                           {sw_o, tmr_o, ext_o}, {m_msip, e_timer, e_ext}); end
      checks++; if (fast_o !== (m_fastip & m_fastie)) begin
        errors++; $display("FAIL rnd_fast[%0d] got %h expected %h", n, fast_o, m_fastip & m_fastie); end
    end
    bus.data_req = 1'b0; tick = 1'b0; ext = 1'b0; src = '0;
    tick_clk();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, rv;
    bus_op(1'b1, 4'h1, Base, 32'h1, rd, er, rv);
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = Base;
    rst = 1'b1;
    tick_clk();
    checks++; if ({bus.data_rvalid, sw_o} !== 2'b00) begin
      errors++; $display("FAIL reset_mid got rv/sw=%b expected 00", {bus.data_rvalid, sw_o}); end
    rst = 1'b0; bus.data_req = 1'b0;
    tick_clk();
    checks++; if (bus.data_rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after got rv=%b expected 0", bus.data_rvalid); end
    bus_op(1'b0, 4'hF, Base + 32'hBFF8, 32'h0, rd, er, rv);
    checks++; if ({rv, rd} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL reset_mid_mtime got rv=%b data=%h expected 1 0", rv, rd); end
  endtask

  initial begin
    test_reset();
    test_mtime_carry();
    test_timer();
    test_fast();
    test_msip();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
